// File: rtl/parity_pkg.sv
// Shared types and sizing helpers for the serial parity checker.
// Index width is derived from the frame width at elaboration.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int idx_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_WIDTH);

endpackage

// File: rtl/serial_parity_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: WIDTH data bits LSB first, then a parity bit.
// Reports a registered per-frame result and counts errored frames.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             odd_mode,
  input  logic             clr_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int IW = idx_w(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_idx;
  logic             r_acc;
  logic             r_odd;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_done;
  logic             r_err;
  logic             w_last;
  logic             w_par_acc;
  logic             w_par_err;

  assign w_last    = (r_idx == IW'(WIDTH - 1));
  assign w_par_acc = in_valid && (r_state == PARITY);
  assign w_par_err = r_acc ^ in_bit ^ r_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_next = (WIDTH == 1) ? PARITY : DATA;
      end
      DATA: begin
        if (in_valid && w_last) w_next = PARITY;
      end
      PARITY: begin
        if (in_valid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_acc   <= 1'b0;
      r_odd   <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (in_valid) begin
        unique case (r_state)
          IDLE: begin
            r_shift <= WIDTH'(in_bit);
            r_acc   <= in_bit;
            r_odd   <= odd_mode;
            r_idx   <= IW'(1);
          end
          DATA: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (r_idx == IW'(i)) r_shift[i] <= in_bit;
            end
            r_acc <= r_acc ^ in_bit;
            r_idx <= r_idx + IW'(1);
          end
          PARITY: begin
            r_err  <= w_par_err;
            r_data <= r_shift;
            r_done <= 1'b1;
            r_idx  <= '0;
            r_acc  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (w_par_acc && w_par_err),
    .count(err_cnt)
  );

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign data_out = r_data;

endmodule
